pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Program-counter unit for the multicycle core: owns the PC and EPC registers and a
//  next-PC source mux generalised in width and increment. Adds conditional (branch)
//  writes, a stall input and a 3-state exception FSM that saves EPC and redirects the
//  PC to a per-cause vector. Sits between the control unit, the ALU/ALUOut datapath and
//  the instruction-address input of memory.
// PARAMETERS
//  WIDTH     32           PC/EPC/data width, >= 8
//  RESET_PC  0            pc_out value after reset
//  PC_INC    4            instruction size; EPC = pc_out - PC_INC
//  EXC_BASE  32'h000000FD exception vector base; vector = EXC_BASE + cause
// PORTS
//  clk            in   1      clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  pc_src         in   2      00 jump_target, 01 alu_result (PC+INC), 10 alu_out (branch), 11 EPC
//  pc_write       in   1      unconditional PC write
//  pc_write_cond  in   1      PC write qualified by branch_cond
//  branch_cond    in   1      branch condition from ALU flags
//  stall          in   1      suppresses normal PC writes
//  jump_target    in   WIDTH  precomputed jump address
//  alu_result     in   WIDTH  sequential PC (PC+INC)
//  alu_out        in   WIDTH  branch target held in ALUOut
//  exc_req        in   1      exception request, sampled in IDLE only
//  exc_cause      in   2      0 bad opcode, 1 overflow, 2 divide-by-zero, 3 reserved
//  pc_out         out  WIDTH  current PC
//  epc_out        out  WIDTH  saved exception PC
//  exc_busy       out  1      high in SAVE and VECTOR
//  exc_ack        out  1      1-cycle pulse in VECTOR
//  pc_written     out  1      registered strobe: PC changed at the previous edge
// BEHAVIOUR
//  - Reset (async, reset_n=0): pc_out=RESET_PC, epc_out=0, state=IDLE, exc_busy=0,
//    exc_ack=0, pc_written=0, cause_q=0. Reset mid-exception aborts it and returns to IDLE.
//  - wr_en = (pc_write | (pc_write_cond & branch_cond)) & ~stall & (state==IDLE) & ~exc_req.
//  - wr_en: pc_out <= mux(pc_src) at the next edge (1-cycle latency); pc_written=1 next cycle.
//  - pc_src=11 loads the internal epc_out (value before the edge).
//  - FSM: IDLE --exc_req--> SAVE --> VECTOR --> IDLE (unconditional after SAVE).
//    IDLE & exc_req edge: cause_q<=exc_cause; epc_out<=pc_out-PC_INC (mod 2^WIDTH).
//    SAVE edge: pc_out<=EXC_BASE+cause_q (zero-extended, mod 2^WIDTH); pc_written=1 next.
//    VECTOR: exc_ack=1; PC and EPC hold.
//  - Priority: exc_req in IDLE beats any simultaneous PC write (the write is dropped).
//  - exc_req in SAVE/VECTOR is ignored (no nesting, no queuing).
//  - stall affects only normal writes; the exception FSM advances regardless.
//  - All arithmetic wraps modulo 2^WIDTH: pc_out=0 with PC_INC=4 gives EPC=2^WIDTH-4.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: a normal write whose target has any of the low log2(PC_INC)
//    bits set is dropped and treated as exc_req with cause 3 at the same edge.
//    The FSM enters SAVE, and EPC = pc_out - PC_INC.
//  Undefined: targets are written unchecked; cause 3 occurs only via exc_req.
// TESTING
//  1 reset_n=0 mid-run -> pc_out=0, epc_out=0, exc_busy=0 with no clock edge.
//  2 pc_src=01, alu_result=0x8, pc_write=1 -> pc_out=0x8 next cycle, pc_written=1;
//    same write with stall=1 -> pc_out holds.
//  3 pc_write_cond=1, alu_out=0x40: branch_cond=0 -> PC holds; branch_cond=1 -> pc_out=0x40.
//  4 pc_out=0x20, exc_req=1, cause=1, pc_write=1 -> epc_out=0x1C, then pc_out=0xFE,
//    exc_ack pulses 1 cycle in VECTOR.
//  5 After test 4: pc_src=11, pc_write=1 -> pc_out=0x1C; exc_req during SAVE -> ignored.
//  6 PC_ALIGN_CHECK_EN, jump_target=0x102 -> no write, epc_out=pc_out-4, pc_out=0x100.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter unit: PC/EPC registers, next-PC mux and a 3-state exception FSM.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned normal writes raise cause 3).
module pc_next_unit #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned      PC_INC   = 4,
   parameter logic [WIDTH-1:0] EXC_BASE = WIDTH'(32'h000000FD)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       pc_src,
   input  logic             pc_write,
   input  logic             pc_write_cond,
   input  logic             branch_cond,
   input  logic             stall,
   input  logic [WIDTH-1:0] jump_target,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             exc_req,
   input  logic [1:0]       exc_cause,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] epc_out,
   output logic             exc_busy,
   output logic             exc_ack,
   output logic             pc_written
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SAVE   = 2'd1;
   localparam logic [1:0] VECTOR = 2'd2;

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(PC_INC);

   logic [1:0]       state;
   logic [1:0]       cause_q;
   logic [WIDTH-1:0] next_pc;
   logic             wr_req;
   logic             wr_en;
   logic             take_exc;
   logic [1:0]       take_cause;

   // Next-PC source selection
   always_comb begin
      next_pc = jump_target;
      case (pc_src)
         2'b00:   next_pc = jump_target;
         2'b01:   next_pc = alu_result;
         2'b10:   next_pc = alu_out;
         2'b11:   next_pc = epc_out;
         default: next_pc = jump_target;
      endcase
   end

   assign wr_req = (pc_write | (pc_write_cond & branch_cond)) & ~stall & (state == IDLE);

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(PC_INC - 32'd1);
   logic misaligned;
   assign misaligned = (next_pc & ALIGN_MASK) != '0;

   // A misaligned normal write turns into a cause-3 exception at the same edge
   always_comb begin
      take_exc   = 1'b0;
      take_cause = 2'd0;
      wr_en      = 1'b0;
      if (state == IDLE) begin
         take_exc   = exc_req | (wr_req & misaligned);
         take_cause = exc_req ? exc_cause : 2'd3;
         wr_en      = wr_req & ~misaligned & ~exc_req;
      end else begin
         take_exc   = 1'b0;
         take_cause = 2'd0;
         wr_en      = 1'b0;
      end
   end
`else
   // Exception request in IDLE wins over any simultaneous normal write
   always_comb begin
      take_exc   = 1'b0;
      take_cause = 2'd0;
      wr_en      = 1'b0;
      if (state == IDLE) begin
         take_exc   = exc_req;
         take_cause = exc_cause;
         wr_en      = wr_req & ~exc_req;
      end else begin
         take_exc   = 1'b0;
         take_cause = 2'd0;
         wr_en      = 1'b0;
      end
   end
`endif

   // PC, EPC, exception FSM and registered status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cause_q    <= 2'd0;
         pc_out     <= RESET_PC;
         epc_out    <= '0;
         exc_busy   <= 1'b0;
         exc_ack    <= 1'b0;
         pc_written <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               exc_ack <= 1'b0;
               if (take_exc) begin
                  state      <= SAVE;
                  cause_q    <= take_cause;
                  epc_out    <= pc_out - INC_W;
                  exc_busy   <= 1'b1;
                  pc_written <= 1'b0;
               end else begin
                  if (wr_en) begin
                     pc_out <= next_pc;
                  end
                  exc_busy   <= 1'b0;
                  pc_written <= wr_en;
               end
            end
            SAVE: begin
               state      <= VECTOR;
               pc_out     <= EXC_BASE + WIDTH'(cause_q);
               exc_busy   <= 1'b1;
               exc_ack    <= 1'b1;
               pc_written <= 1'b1;
            end
            VECTOR: begin
               state      <= IDLE;
               exc_busy   <= 1'b0;
               exc_ack    <= 1'b0;
               pc_written <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               exc_busy   <= 1'b0;
               exc_ack    <= 1'b0;
               pc_written <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit (default parameters).
// Expectations for the misaligned-jump step follow PC_ALIGN_CHECK_EN.
module tb_pc_next_unit;

   logic        clk;
   logic        reset_n;
   logic [1:0]  pc_src;
   logic        pc_write;
   logic        pc_write_cond;
   logic        branch_cond;
   logic        stall;
   logic [31:0] jump_target;
   logic [31:0] alu_result;
   logic [31:0] alu_out;
   logic        exc_req;
   logic [1:0]  exc_cause;
   logic [31:0] pc_out;
   logic [31:0] epc_out;
   logic        exc_busy;
   logic        exc_ack;
   logic        pc_written;

   int n_checks = 0;
   int n_fail   = 0;

   pc_next_unit dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_src        (pc_src),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .branch_cond   (branch_cond),
      .stall         (stall),
      .jump_target   (jump_target),
      .alu_result    (alu_result),
      .alu_out       (alu_out),
      .exc_req       (exc_req),
      .exc_cause     (exc_cause),
      .pc_out        (pc_out),
      .epc_out       (epc_out),
      .exc_busy      (exc_busy),
      .exc_ack       (exc_ack),
      .pc_written    (pc_written)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; pc_src = 2'b00; pc_write = 1'b0; pc_write_cond = 1'b0;
      branch_cond = 1'b0; stall = 1'b0; jump_target = 32'h0; alu_result = 32'h0;
      alu_out = 32'h0; exc_req = 1'b0; exc_cause = 2'd0;
      #3;
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_epc", epc_out, 32'h0);
      chk("rst_busy", {31'd0, exc_busy}, 32'd0);
      chk("rst_ack", {31'd0, exc_ack}, 32'd0);
      chk("rst_written", {31'd0, pc_written}, 32'd0);
      step();
      reset_n = 1'b1;

      // sequential write, then stalled write
      pc_src = 2'b01; alu_result = 32'h8; pc_write = 1'b1;
      step();
      chk("seq_pc", pc_out, 32'h8);
      chk("seq_written", {31'd0, pc_written}, 32'd1);
      stall = 1'b1; alu_result = 32'hC;
      step();
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_written", {31'd0, pc_written}, 32'd0);
      stall = 1'b0; pc_write = 1'b0;

      // conditional branch
      pc_src = 2'b10; alu_out = 32'h40; pc_write_cond = 1'b1; branch_cond = 1'b0;
      step();
      chk("bnt_pc", pc_out, 32'h8);
      chk("bnt_written", {31'd0, pc_written}, 32'd0);
      branch_cond = 1'b1;
      step();
      chk("bt_pc", pc_out, 32'h40);
      chk("bt_written", {31'd0, pc_written}, 32'd1);
      pc_write_cond = 1'b0; branch_cond = 1'b0;

      // jump to 0x20, then exception cause 1 with a colliding write
      pc_src = 2'b00; jump_target = 32'h20; pc_write = 1'b1;
      step();
      chk("jmp_pc", pc_out, 32'h20);
      jump_target = 32'h80; exc_req = 1'b1; exc_cause = 2'd1;
      step();
      chk("save_epc", epc_out, 32'h1C);
      chk("save_pc", pc_out, 32'h20);
      chk("save_busy", {31'd0, exc_busy}, 32'd1);
      chk("save_ack", {31'd0, exc_ack}, 32'd0);
      chk("save_written", {31'd0, pc_written}, 32'd0);
      exc_cause = 2'd2;   // request during SAVE must be ignored
      step();
      chk("vec_pc", pc_out, 32'hFE);
      chk("vec_ack", {31'd0, exc_ack}, 32'd1);
      chk("vec_busy", {31'd0, exc_busy}, 32'd1);
      chk("vec_written", {31'd0, pc_written}, 32'd1);
      chk("vec_epc", epc_out, 32'h1C);
      exc_req = 1'b0; pc_write = 1'b0;
      step();
      chk("idle_ack", {31'd0, exc_ack}, 32'd0);
      chk("idle_busy", {31'd0, exc_busy}, 32'd0);
      chk("idle_pc", pc_out, 32'hFE);

      // return via EPC
      pc_src = 2'b11; pc_write = 1'b1;
      step();
      chk("epc_ret_pc", pc_out, 32'h1C);
      chk("epc_ret_written", {31'd0, pc_written}, 32'd1);
      pc_write = 1'b0;

      // reset mid-exception, no clock edge
      exc_req = 1'b1; exc_cause = 2'd0;
      step();
      chk("abort_epc_pre", epc_out, 32'h18);
      chk("abort_busy_pre", {31'd0, exc_busy}, 32'd1);
      exc_req = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("abort_pc", pc_out, 32'h0);
      chk("abort_epc", epc_out, 32'h0);
      chk("abort_busy", {31'd0, exc_busy}, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_busy", {31'd0, exc_busy}, 32'd0);
      chk("post_rst_pc", pc_out, 32'h0);

      // EPC wrap from pc_out=0, cause 3 vector
      exc_req = 1'b1; exc_cause = 2'd3;
      step();
      chk("wrap_epc", epc_out, 32'hFFFF_FFFC);
      exc_req = 1'b0;
      step();
      chk("c3_pc", pc_out, 32'h100);
      step();
      chk("c3_idle_busy", {31'd0, exc_busy}, 32'd0);

      // misaligned jump target
      pc_src = 2'b00; jump_target = 32'h102; pc_write = 1'b1;
      step();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_pc_hold", pc_out, 32'h100);
      chk("mis_epc", epc_out, 32'hFC);
      chk("mis_busy", {31'd0, exc_busy}, 32'd1);
      pc_write = 1'b0;
      step();
      chk("mis_vec_pc", pc_out, 32'h100);
      chk("mis_vec_ack", {31'd0, exc_ack}, 32'd1);
`else
      chk("mis_pc", pc_out, 32'h102);
      chk("mis_busy", {31'd0, exc_busy}, 32'd0);
      chk("mis_epc", epc_out, 32'hFFFF_FFFC);
      pc_write = 1'b0;
      step();
      chk("mis_hold", pc_out, 32'h102);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
